// File: rtl/data_mem.sv
// Byte-addressable data memory with 64-bit little-endian doubleword access.
// Accesses may be unaligned and wrap modulo MEM_BYTES; reads are registered.
module data_mem #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [63:0] read_data
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    mem_d [MEM_BYTES];
  logic [63:0]   read_data_q;
  logic [63:0]   read_data_d;
  logic [63:0]   rd_word_s;
  logic [AW-1:0] base_s;
  logic          unused_addr_s;

  // Byte k of a doubleword; the AW-bit sum wraps the index modulo MEM_BYTES.
  function automatic logic [AW-1:0] byte_index(input logic [AW-1:0] base, input int k);
    return base + AW'(k);
  endfunction

  assign base_s        = address[AW-1:0];
  assign unused_addr_s = ^address[63:AW];

  // Gather the current (pre-write) doubleword at the access address.
  always_comb begin
    rd_word_s = 64'h0;
    for (int k = 0; k < 8; k++) begin
      rd_word_s[8*k +: 8] = mem_q[byte_index(base_s, k)];
    end
  end

  // Next memory contents: full 8-byte write when enabled, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    if (MemWrite) begin
      for (int k = 0; k < 8; k++) begin
        mem_d[byte_index(base_s, k)] = write_data[8*k +: 8];
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Read register loads only on MemRead, so read-during-write returns old data.
  always_comb begin
    if (MemRead) begin
      read_data_d = rd_word_s;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // State update; reset clears every byte and overrides any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
      read_data_q <= 64'h0;
    end else begin
      mem_q       <= mem_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem with hand-computed expected values.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] read_data;

  int n_tests;
  int n_fail;

  data_mem #(.MEM_BYTES(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .write_data (write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // One clock edge with the given controls; outputs are stable 1 time unit later.
  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [63:0] addr, input logic [63:0] data);
    reset      = rst;
    MemRead    = rd;
    MemWrite   = wr;
    address    = addr;
    write_data = data;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data);
    step(1'b0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic rd_check(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    step(1'b0, 1'b1, 1'b0, addr, 64'h0);
    check_eq(tag, read_data, exp);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    address    = 64'h0;
    write_data = 64'h0;

    step(1'b1, 1'b0, 1'b0, 64'd0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'd0, 64'h0);
    check_eq("reset_rdata", read_data, 64'h0);
    rd_check("reset_mem100", 64'd100, 64'h0);

    // Unaligned write/read and hold while MemRead is low.
    wr(64'd100, 64'h1122334455667788);
    rd_check("rd100", 64'd100, 64'h1122334455667788);
    wr(64'd600, 64'h9999999999999999);
    check_eq("hold_after_rd", read_data, 64'h1122334455667788);
    step(1'b0, 1'b0, 1'b0, 64'd200, 64'h0);
    check_eq("hold_idle", read_data, 64'h1122334455667788);

    wr(64'd200, 64'hdeadbeefcafebabe);
    wr(64'd300, 64'hffffffffffffffff);
    wr(64'd400, 64'h0000000000000000);
    rd_check("rd200", 64'd200, 64'hdeadbeefcafebabe);
    rd_check("rd300", 64'd300, 64'hffffffffffffffff);
    rd_check("rd400", 64'd400, 64'h0000000000000000);
    rd_check("rd600", 64'd600, 64'h9999999999999999);

    // Byte-offset read mixes in an untouched byte 16.
    wr(64'd8, 64'h0807060504030201);
    rd_check("rd9_offset", 64'd9, 64'h0008070605040302);
    rd_check("rd8", 64'd8, 64'h0807060504030201);

    // Wrap-around at the top of memory.
    wr(64'd1020, 64'hAABBCCDDEEFF0011);
    rd_check("rd1020_wrap", 64'd1020, 64'hAABBCCDDEEFF0011);
    rd_check("rd0_wrapped", 64'd0, 64'h00000000AABBCCDD);
    rd_check("rd1022_wrap", 64'd1022, 64'h0000AABBCCDDEEFF);

    // Upper address bits are ignored.
    rd_check("upper_addr", 64'h0000_0001_0000_0064, 64'h1122334455667788);
    rd_check("upper_addr_hi", 64'h8000_0000_0000_00C8, 64'hdeadbeefcafebabe);

    // Read-during-write returns old data, then new data.
    wr(64'd100, 64'h0123456789abcdef);
    step(1'b0, 1'b1, 1'b1, 64'd100, 64'hfedcba9876543210);
    check_eq("rdw_old", read_data, 64'h0123456789abcdef);
    rd_check("rdw_new", 64'd100, 64'hfedcba9876543210);

    // Reset mid-sequence wins over a concurrent read and write.
    wr(64'd100, 64'h5555aaaa5555aaaa);
    rd_check("pre_reset", 64'd100, 64'h5555aaaa5555aaaa);
    step(1'b1, 1'b1, 1'b1, 64'd500, 64'h0000000000000abc);
    check_eq("reset_mid_rdata", read_data, 64'h0);
    rd_check("reset_mid_100", 64'd100, 64'h0);
    rd_check("reset_no_write", 64'd500, 64'h0);
    rd_check("reset_mid_1020", 64'd1020, 64'h0);
    rd_check("reset_mid_200", 64'd200, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
